// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundles the requester-side and memory-side signals of the shared memory port arbiter.
// Latency: none. This file only declares wires.
// Backpressure: gnt_o to the requesters and mem_gnt_i from the memory carry the handshake.
//
// Ports / modports:
//   slave  : arbiter view. It samples requester and memory inputs and drives grants, responses and memory outputs.
//   master : environment view. The requesters plus the memory drive the _i side and observe the _o side.
//   addr_i, wdata_i and be_i are flattened. Requester r uses [32*r +: 32] or [4*r +: 4].
interface mem_port_arbiter_if #(
    parameter int NUM_REQ = 2
);
    // requester side
    logic [NUM_REQ-1:0]    req_i;
    logic [32*NUM_REQ-1:0] addr_i;
    logic [NUM_REQ-1:0]    we_i;
    logic [4*NUM_REQ-1:0]  be_i;
    logic [32*NUM_REQ-1:0] wdata_i;
    logic [NUM_REQ-1:0]    gnt_o;
    logic [NUM_REQ-1:0]    rvalid_o;
    logic [31:0]           rdata_o;
    logic                  err_o;
    // memory side
    logic                  mem_req_o;
    logic [31:0]           mem_addr_o;
    logic                  mem_we_o;
    logic [3:0]            mem_be_o;
    logic [31:0]           mem_wdata_o;
    logic                  mem_gnt_i;
    logic                  mem_rvalid_i;
    logic [31:0]           mem_rdata_i;
    logic                  mem_err_i;
    // status
    logic                  unexp_rsp_o;

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o,
        output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
        output unexp_rsp_o
    );

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o,
        input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
        input  unexp_rsp_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: round-robin sharing of one 32-bit memory port among NUM_REQ requesters, with in-order response routing.
// Latency: 0 cycles each way. A grant follows mem_gnt_i combinationally, and a response follows mem_rvalid_i combinationally.
// Backpressure: mem_req_o is held low once MAX_OUTST requests are outstanding, unless a response frees a slot in the same cycle.
//
// Ports:
//   clk_i, rst_i : clock and synchronous active-high reset.
//   bus (slave)  : requester req/addr/we/be/wdata -> gnt/rvalid/rdata/err.
//                  memory req/addr/we/be/wdata <- gnt/rvalid/rdata/err.
//                  unexp_rsp_o is sticky. It is set when a response arrives with nothing outstanding.

// Small generic FIFO. The caller must not push when the FIFO is full unless it also pops in that cycle.
// The caller must never pop when the FIFO is empty.
// rd_dat is the current head. It is combinational from the storage, so a same-cycle push into the
// slot being popped (full + pop + push) still returns the old head.
module id_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_vld,
    input  logic [W-1:0]           wr_dat,
    input  logic                   rd_rdy,
    output logic [W-1:0]           rd_dat,
    output logic [$clog2(DEPTH):0] cnt
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  store [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // DEPTH is a power of 2, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_vld) wr_ptr <= wr_ptr + 1'b1;
            if (rd_rdy) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_vld, rd_rdy})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_vld) store[wr_ptr] <= wr_dat;
    end

    assign rd_dat = store[rd_ptr];
endmodule

module mem_port_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int MAX_OUTST = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mem_port_arbiter_if.slave bus
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST) + 1;

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  win_id;
    logic             win_vld;
    logic [ID_W-1:0]  head_id;
    logic [CNT_W-1:0] cnt;
    logic             can_issue;
    logic             accept;
    logic             pop;
    logic             unexp_q;

    // Round-robin scan from rr_ptr. Iterating from the farthest offset down lets the closest requester overwrite the others.
    always_comb begin
        int idx;
        idx     = 0;
        win_vld = 1'b0;
        win_id  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (bus.req_i[idx]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(idx);
            end
        end
    end

    // A response arriving this cycle frees a slot, so a full FIFO can still issue.
    assign can_issue = (cnt < CNT_W'(MAX_OUTST)) | bus.mem_rvalid_i;
    assign accept    = bus.mem_req_o & bus.mem_gnt_i;
    assign pop       = ~rst_i & bus.mem_rvalid_i & (cnt != '0);

    assign bus.mem_req_o   = ~rst_i & win_vld & can_issue;
    assign bus.mem_addr_o  = bus.addr_i[32*win_id +: 32];
    assign bus.mem_we_o    = bus.we_i[win_id];
    assign bus.mem_be_o    = bus.be_i[4*win_id +: 4];
    assign bus.mem_wdata_o = bus.wdata_i[32*win_id +: 32];

    always_comb begin
        bus.gnt_o    = '0;
        bus.rvalid_o = '0;
        if (accept) bus.gnt_o[win_id]     = 1'b1;
        if (pop)    bus.rvalid_o[head_id] = 1'b1;
    end

    assign bus.rdata_o     = bus.mem_rdata_i;
    assign bus.err_o       = bus.mem_err_i;
    assign bus.unexp_rsp_o = unexp_q;

    // Holds the IDs of outstanding requests, in the order the memory will answer them.
    id_fifo #(
        .DEPTH (MAX_OUTST),
        .W     (ID_W)
    ) u_id_fifo (
        .clk    (clk_i),
        .rst    (rst_i),
        .wr_vld (accept),
        .wr_dat (win_id),
        .rd_rdy (pop),
        .rd_dat (head_id),
        .cnt    (cnt)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr  <= '0;
            unexp_q <= 1'b0;
        end else begin
            if (accept) begin
                if (int'(win_id) == NUM_REQ - 1) rr_ptr <= '0;
                else                             rr_ptr <= win_id + 1'b1;
            end
            if (bus.mem_rvalid_i && cnt == '0) unexp_q <= 1'b1;
        end
    end
endmodule
